// File: rtl/instr_fetch.sv
// Instruction fetch unit: one outstanding imem read at a time, captured word and PC
// offered to decode over valid/ready; redirects accepted in any cycle.
module instr_fetch #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic [63:0] pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  input  logic        redirect,
  input  logic [63:0] redirect_pc,
  output logic        fetch_fault,
  output logic [1:0]  state_dbg
);

  // Handshakes:
  //   imem: imem_req stays high with a stable imem_addr until the cycle imem_ack=1;
  //         the transfer completes in that cycle and imem_rdata is sampled then.
  //   decode: inst/pc are transferred in a cycle where inst_valid && inst_ready;
  //         inst_valid never drops without a transfer except on redirect or fault.
  typedef enum logic [1:0] {
    FETCH = 2'd0,
    ISSUE = 2'd1,
    FAULT = 2'd2
  } state_t;

  state_t      state, state_n;
  logic [63:0] fetch_pc, fetch_pc_n;
  logic [63:0] next_pc, next_pc_n;
  logic [63:0] pc_q, pc_n;
  logic [31:0] inst_q, inst_n;
  logic        drop, drop_n;
  logic        pend_fault, pend_n;
  logic        fault_q, fault_n;
  logic        misaligned;

  assign misaligned  = (redirect_pc[1:0] != 2'b00);
  assign imem_req    = (state == FETCH) && !reset;
  assign imem_addr   = fetch_pc;
  assign inst        = inst_q;
  assign pc          = pc_q;
  assign inst_valid  = (state == ISSUE);
  assign fetch_fault = fault_q;
  assign state_dbg   = state;

  always_comb begin
    state_n    = state;
    fetch_pc_n = fetch_pc;
    next_pc_n  = next_pc;
    pc_n       = pc_q;
    inst_n     = inst_q;
    drop_n     = drop;
    pend_n     = pend_fault;
    fault_n    = fault_q;
    case (state)
      FETCH: begin
        if (redirect && misaligned) begin
          // The fault is flagged now, but an in-flight read must finish first.
          fault_n = 1'b1;
          inst_n  = NOP_INST;
          if (imem_ack) begin
            state_n = FAULT;
            drop_n  = 1'b0;
            pend_n  = 1'b0;
          end else begin
            drop_n = 1'b1;
            pend_n = 1'b1;
          end
        end else if (imem_ack) begin
          drop_n = 1'b0;
          if (pend_fault) begin
            state_n = FAULT;
            pend_n  = 1'b0;
          end else if (redirect) begin
            fetch_pc_n = redirect_pc;
          end else if (drop) begin
            fetch_pc_n = next_pc;
          end else begin
            inst_n     = imem_rdata;
            pc_n       = fetch_pc;
            fetch_pc_n = fetch_pc + 64'd4;
            state_n    = ISSUE;
          end
        end else if (redirect && !pend_fault) begin
          // Keep imem_addr stable; the target is fetched after the old ack.
          next_pc_n = redirect_pc;
          drop_n    = 1'b1;
        end
      end
      ISSUE: begin
        if (redirect) begin
          inst_n = NOP_INST;
          if (misaligned) begin
            fault_n = 1'b1;
            state_n = FAULT;
          end else begin
            fetch_pc_n = redirect_pc;
            state_n    = FETCH;
          end
        end else if (inst_ready) begin
          state_n = FETCH;
        end
      end
      FAULT: begin
        state_n = FAULT;
      end
      default: begin
        state_n = FETCH;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= FETCH;
      fetch_pc   <= RESET_PC;
      next_pc    <= RESET_PC;
      pc_q       <= RESET_PC;
      inst_q     <= NOP_INST;
      drop       <= 1'b0;
      pend_fault <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state      <= state_n;
      fetch_pc   <= fetch_pc_n;
      next_pc    <= next_pc_n;
      pc_q       <= pc_n;
      inst_q     <= inst_n;
      drop       <= drop_n;
      pend_fault <= pend_n;
      fault_q    <= fault_n;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: reset/zero-wait vector table, hand-written corner sequences,
// and random traffic checked against a delivered-stream model of the fetch unit.
module tb_instr_fetch;

  localparam logic [63:0] RPC = 64'h1000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] inst;
  logic [63:0] pc;
  logic        inst_valid;
  logic        inst_ready;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic        fetch_fault;
  logic [1:0]  state_dbg;

  instr_fetch #(.RESET_PC(RPC), .NOP_INST(NOP)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .inst(inst), .pc(pc), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .redirect(redirect), .redirect_pc(redirect_pc), .fetch_fault(fetch_fault),
    .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, got, want, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'h5A3C_0F13;
  endfunction

  // ---------------- memory and reference model state ----------------
  int          mwaits = 0;
  int          mcnt   = 0;
  logic        prev_wait = 1'b0;
  logic [63:0] prev_addr = '0;

  logic [63:0] m_exp_pc;
  logic        m_faulted;
  logic        m_req_off;
  int          m_deliv;

  task automatic model_reset();
    m_exp_pc  = RPC;
    m_faulted = 1'b0;
    m_req_off = 1'b0;
    m_deliv   = 0;
    prev_wait = 1'b0;
    mcnt      = 0;
  endtask

  // Model: the decode stage sees the straight-line stream from the last redirect
  // target (or RESET_PC); any misaligned redirect ends the stream for good.
  task automatic model_step();
    chk("fault_flag", fetch_fault, m_faulted);
    if (m_faulted) begin
      chk("fault_valid", inst_valid, 1'b0);
      chk("fault_inst", inst, NOP);
      if (!imem_req) m_req_off = 1'b1;
      else if (m_req_off) chk("req_after_fault", imem_req, 1'b0);
    end else begin
      if (inst_valid) begin
        chk("model_pc", pc, m_exp_pc);
        chk("model_inst", inst, mem_word(m_exp_pc));
      end
      if (redirect) begin
        if (redirect_pc[1:0] != 2'b00) m_faulted = 1'b1;
        else m_exp_pc = redirect_pc;
      end else if (inst_valid && inst_ready) begin
        m_exp_pc = m_exp_pc + 64'd4;
        m_deliv++;
      end
    end
  endtask

  // ---------------- driver ----------------
  // Called just after a rising edge: drive inputs, answer memory, check, advance one cycle.
  task automatic cycle(input logic rd, input logic [63:0] rpc, input logic rdy);
    redirect    = rd;
    redirect_pc = rpc;
    inst_ready  = rdy;
    if (prev_wait && imem_req) chk("addr_stable", imem_addr, prev_addr);
    if (imem_req) begin
      if (mcnt >= mwaits) begin
        imem_ack   = 1'b1;
        imem_rdata = mem_word(imem_addr);
        mcnt       = 0;
      end else begin
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
        mcnt++;
      end
    end else begin
      imem_ack   = 1'b0;
      imem_rdata = $urandom;
      mcnt       = 0;
    end
    prev_wait = imem_req && !imem_ack;
    prev_addr = imem_addr;
    #1;
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    redirect    = 1'b0;
    redirect_pc = '0;
    inst_ready  = 1'b0;
    imem_ack    = 1'b0;
    imem_rdata  = '0;
    repeat (2) begin
      @(posedge clk);
      #1;
      chk("req_in_reset", imem_req, 1'b0);
    end
    reset = 1'b0;
    model_reset();
    #1;
  endtask

  task automatic expect_out(input string tag, input logic req, input logic [63:0] addr,
                            input logic valid, input logic [63:0] p, input logic [31:0] ins,
                            input logic flt);
    chk({tag, "_req"}, imem_req, req);
    if (req) chk({tag, "_addr"}, imem_addr, addr);
    chk({tag, "_valid"}, inst_valid, valid);
    chk({tag, "_pc"}, pc, p);
    chk({tag, "_inst"}, inst, ins);
    chk({tag, "_fault"}, fetch_fault, flt);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        rd;
    logic [63:0] rpc;
    logic        rdy;
    logic        exp_req;
    logic [63:0] exp_addr;
    logic        exp_valid;
    logic [63:0] exp_pc;
    logic [31:0] exp_inst;
    logic        exp_fault;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rdy, input logic req, input logic [63:0] addr,
                     input logic valid, input logic [63:0] p, input logic [31:0] ins);
    vec_t v;
    v.rd = 1'b0; v.rpc = '0; v.rdy = rdy;
    v.exp_req = req; v.exp_addr = addr; v.exp_valid = valid;
    v.exp_pc = p; v.exp_inst = ins; v.exp_fault = 1'b0;
    vecs.push_back(v);
  endtask

  // ---------------- main ----------------
  initial begin
    reset = 1'b1;
    redirect = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
    imem_ack = 1'b0; imem_rdata = '0;

    // Zero-wait memory: fetch/issue alternate, then a 5-cycle decode stall.
    add(1, 1, 64'h1000, 0, 64'h1000, NOP);
    add(1, 0, 0,        1, 64'h1000, mem_word(64'h1000));
    add(1, 1, 64'h1004, 0, 64'h1000, mem_word(64'h1000));
    add(1, 0, 0,        1, 64'h1004, mem_word(64'h1004));
    add(0, 1, 64'h1008, 0, 64'h1004, mem_word(64'h1004));
    for (int i = 0; i < 5; i++) add(0, 0, 0, 1, 64'h1008, mem_word(64'h1008));
    add(1, 0, 0,        1, 64'h1008, mem_word(64'h1008));
    add(1, 1, 64'h100C, 0, 64'h1008, mem_word(64'h1008));
    add(1, 0, 0,        1, 64'h100C, mem_word(64'h100C));

    mwaits = 0;
    do_reset();
    for (int i = 0; i < vecs.size(); i++) begin
      expect_out($sformatf("vec%0d", i), vecs[i].exp_req, vecs[i].exp_addr, vecs[i].exp_valid,
                 vecs[i].exp_pc, vecs[i].exp_inst, vecs[i].exp_fault);
      cycle(vecs[i].rd, vecs[i].rpc, vecs[i].rdy);
    end

    // 3 wait states, then redirect to 0x2000 while 0x1004 is outstanding.
    mwaits = 3;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      expect_out("ws_fetch", 1, 64'h1000, 0, RPC, NOP, 0);
      cycle(0, 0, 1);
    end
    expect_out("ws_issue", 0, 0, 1, 64'h1000, mem_word(64'h1000), 0);
    cycle(0, 0, 1);
    chk("rd_addr0", imem_addr, 64'h1004);
    cycle(1, 64'h2000, 1);
    for (int i = 0; i < 2; i++) begin
      expect_out("rd_wait", 1, 64'h1004, 0, 64'h1000, mem_word(64'h1000), 0);
      cycle(0, 0, 1);
    end
    chk("rd_ack_valid", inst_valid, 1'b0);
    cycle(0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      expect_out("rd_target", 1, 64'h2000, 0, 64'h1000, mem_word(64'h1000), 0);
      cycle(0, 0, 1);
    end
    expect_out("rd_deliver", 0, 0, 1, 64'h2000, mem_word(64'h2000), 0);
    cycle(0, 0, 1);

    // Redirect from ISSUE to the top word; fetch_pc+4 wraps to 0.
    mwaits = 0;
    do_reset();
    cycle(0, 0, 1);
    cycle(1, 64'hFFFF_FFFF_FFFF_FFFC, 1);
    expect_out("wrap_req", 1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 64'h1000, NOP, 0);
    cycle(0, 0, 1);
    expect_out("wrap_issue", 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC, mem_word(64'hFFFF_FFFF_FFFF_FFFC), 0);
    cycle(0, 0, 1);
    expect_out("wrap_zero", 1, 64'h0, 0, 64'hFFFF_FFFF_FFFF_FFFC,
               mem_word(64'hFFFF_FFFF_FFFF_FFFC), 0);
    cycle(0, 0, 1);
    expect_out("wrap_deliver", 0, 0, 1, 64'h0, mem_word(64'h0), 0);
    cycle(0, 0, 1);

    // Misaligned redirect from ISSUE.
    do_reset();
    cycle(0, 0, 1);
    cycle(1, 64'h2002, 1);
    for (int i = 0; i < 6; i++) begin
      expect_out("flt_issue", 0, 0, 0, 64'h1000, NOP, 1);
      cycle(1'($urandom_range(0, 1)), 64'h3000, 1'($urandom_range(0, 1)));
    end

    // Misaligned redirect while a read is outstanding: read completes, then stop.
    mwaits = 2;
    do_reset();
    cycle(1, 64'h2002, 1);
    expect_out("flt_pend", 1, 64'h1000, 0, RPC, NOP, 1);
    cycle(0, 0, 1);
    cycle(0, 0, 1);
    for (int i = 0; i < 6; i++) begin
      expect_out("flt_done", 0, 0, 0, RPC, NOP, 1);
      cycle(1'($urandom_range(0, 1)), 64'h3000, 1);
    end
    do_reset();
    expect_out("flt_reset", 1, RPC, 0, RPC, NOP, 0);
    cycle(0, 0, 1);

    // Random traffic against the stream model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      logic        rd;
      logic [63:0] t;
      if (mcnt == 0) mwaits = $urandom_range(0, 3);
      rd = ($urandom_range(0, 15) == 0);
      case ($urandom_range(0, 7))
        0:       t = 64'hFFFF_FFFF_FFFF_FFF8;
        1:       t = 64'hFFFF_FFFF_FFFF_FFFC;
        default: t = {$urandom, $urandom} & ~64'h3;
      endcase
      cycle(rd, t, 1'($urandom_range(0, 3) != 0));
    end
    chk("random_liveness", 64'(m_deliv > 100), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
